// File: rtl/mbist_fi_pkg.sv
// Shared types for the MBIST fault injector and its campaign sequencer.
package mbist_fi_pkg;

  localparam int ROW_BITS = 4;
  localparam int COL_BITS = 4;
  localparam int DATA_W   = 8;
  localparam int BIT_BITS = $clog2(DATA_W);

  typedef enum logic [2:0] {
    NONE = 3'd0,
    SAF  = 3'd1,
    TF   = 3'd2,
    AF   = 3'd3,
    CF   = 3'd4
  } fault_e;

  typedef struct packed {
    logic                valid;
    fault_e              fault_type;
    logic                apply_row;
    logic                apply_col;
    logic                apply_cell;
    logic [ROW_BITS-1:0] target_row;
    logic [COL_BITS-1:0] target_col;
    logic [BIT_BITS-1:0] bit_sel;
    logic                saf_force_value;
    logic [ROW_BITS-1:0] aggr_row;
    logic [COL_BITS-1:0] aggr_col;
  } fault_desc_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    SETTLE = 3'd2,
    RUN    = 3'd3,
    WAIT   = 3'd4,
    RECORD = 3'd5,
    DONE   = 3'd6
  } campaign_state_e;

endpackage

// File: rtl/fault_desc_table.sv
// Fault descriptor register file; only the valid bits are reset.
module fault_desc_table
  import mbist_fi_pkg::*;
#(
  parameter int NUM_FAULTS = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          we,
  input  logic [$clog2(NUM_FAULTS)-1:0] widx,
  input  fault_desc_t                   wdata,
  input  logic [$clog2(NUM_FAULTS)-1:0] ridx,
  output fault_desc_t                   rdata
);

  fault_desc_t mem [NUM_FAULTS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_FAULTS; i++)
        mem[i].valid <= 1'b0;
    end else if (we) begin
      mem[widx] <= wdata;
    end
  end

  assign rdata = mem[ridx];

endmodule

// File: rtl/fault_campaign_ctrl.sv
// Fault-coverage campaign sequencer: one golden MBIST pass, then one
// pass per valid descriptor, recording detections and escapes.
module fault_campaign_ctrl
  import mbist_fi_pkg::*;
#(
  parameter int ROW_ADDR_BITS  = 4,
  parameter int COL_ADDR_BITS  = 4,
  parameter int DATA_WIDTH     = 8,
  parameter int NUM_FAULTS     = 8,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            cfg_we,
  input  logic [$clog2(NUM_FAULTS)-1:0]   cfg_idx,
  input  fault_desc_t                     cfg_wdata,
  input  logic                            campaign_start,
  output logic                            campaign_busy,
  output logic                            campaign_done,
  output logic                            golden_fail,
  output logic                            timeout_err,
  output logic [NUM_FAULTS-1:0]           detected,
  output logic [NUM_FAULTS-1:0]           tested,
  output logic [$clog2(NUM_FAULTS+1)-1:0] escape_count,
  output logic [2:0]                      fi_fault_type,
  output logic                            fi_apply_row,
  output logic                            fi_apply_col,
  output logic                            fi_apply_cell,
  output logic [ROW_ADDR_BITS-1:0]        fi_target_row,
  output logic [COL_ADDR_BITS-1:0]        fi_target_col,
  output logic [$clog2(DATA_WIDTH)-1:0]   fi_bit_sel,
  output logic                            fi_saf_force_value,
  output logic [ROW_ADDR_BITS-1:0]        fi_cf_aggr_row,
  output logic [COL_ADDR_BITS-1:0]        fi_cf_aggr_col,
  output logic                            mbist_start,
  input  logic                            mbist_done,
  input  logic                            mbist_fail
);

  localparam int IW = $clog2(NUM_FAULTS);
  localparam int CW = $clog2(NUM_FAULTS + 1);
  localparam int WW = $clog2(TIMEOUT_CYCLES);
  localparam int BW = $clog2(DATA_WIDTH);
  localparam logic [IW-1:0] LAST    = IW'(NUM_FAULTS - 1);
  localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT_CYCLES - 1);

  campaign_state_e state;
  logic            golden;
  logic            fail_q;
  logic [IW-1:0]   idx;
  logic [WW-1:0]   wdog;
  fault_desc_t     fi_q;
  fault_desc_t     entry;
  logic            unused_fi_valid;

  fault_desc_table #(
    .NUM_FAULTS(NUM_FAULTS)
  ) u_table (
    .clk   (clk),
    .rst   (rst),
    .we    (cfg_we && state == IDLE),
    .widx  (cfg_idx),
    .wdata (cfg_wdata),
    .ridx  (idx),
    .rdata (entry)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      golden        <= 1'b0;
      fail_q        <= 1'b0;
      idx           <= '0;
      wdog          <= '0;
      fi_q          <= '0;
      campaign_done <= 1'b0;
      golden_fail   <= 1'b0;
      timeout_err   <= 1'b0;
      detected      <= '0;
      tested        <= '0;
      escape_count  <= '0;
    end else begin
      unique case (state)
        IDLE: if (campaign_start) begin
          campaign_done <= 1'b0;
          golden_fail   <= 1'b0;
          timeout_err   <= 1'b0;
          detected      <= '0;
          tested        <= '0;
          escape_count  <= '0;
          golden        <= 1'b1;
          idx           <= '0;
          state         <= LOAD;
        end
        LOAD: if (golden) begin
          fi_q  <= '0;
          state <= SETTLE;
        end else if (!entry.valid) begin
          if (idx == LAST) begin
            fi_q  <= '0;
            state <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end else begin
          fi_q  <= entry;
          state <= SETTLE;
        end
        SETTLE: state <= RUN;
        RUN: begin
          wdog  <= '0;
          state <= WAIT;
        end
        // A hung MBIST aborts the whole campaign, not just this pass.
        WAIT: if (mbist_done) begin
          fail_q <= mbist_fail;
          state  <= RECORD;
        end else if (wdog == WD_LAST) begin
          timeout_err <= 1'b1;
          fi_q        <= '0;
          state       <= DONE;
        end else begin
          wdog <= wdog + 1'b1;
        end
        RECORD: if (golden) begin
          if (fail_q) begin
            golden_fail <= 1'b1;
            fi_q        <= '0;
            state       <= DONE;
          end else begin
            golden <= 1'b0;
            idx    <= '0;
            state  <= LOAD;
          end
        end else begin
          tested[idx]   <= 1'b1;
          detected[idx] <= fail_q;
          if (!fail_q)
            escape_count <= escape_count + CW'(1);
          if (idx == LAST) begin
            fi_q  <= '0;
            state <= DONE;
          end else begin
            idx   <= idx + 1'b1;
            state <= LOAD;
          end
        end
        DONE: begin
          campaign_done <= 1'b1;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign campaign_busy      = (state != IDLE);
  assign mbist_start        = (state == RUN);
  assign fi_fault_type      = fi_q.fault_type;
  assign fi_apply_row       = fi_q.apply_row;
  assign fi_apply_col       = fi_q.apply_col;
  assign fi_apply_cell      = fi_q.apply_cell;
  assign fi_target_row      = ROW_ADDR_BITS'(fi_q.target_row);
  assign fi_target_col      = COL_ADDR_BITS'(fi_q.target_col);
  assign fi_bit_sel         = BW'(fi_q.bit_sel);
  assign fi_saf_force_value = fi_q.saf_force_value;
  assign fi_cf_aggr_row     = ROW_ADDR_BITS'(fi_q.aggr_row);
  assign fi_cf_aggr_col     = COL_ADDR_BITS'(fi_q.aggr_col);
  assign unused_fi_valid    = fi_q.valid;

endmodule

// File: tb/tb_fault_campaign_ctrl.sv
// Directed bench for fault_campaign_ctrl with a behavioural MBIST model.
module tb_fault_campaign_ctrl;
  import mbist_fi_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_we = 1'b0;
  logic [2:0]  cfg_idx = '0;
  fault_desc_t cfg_wdata = '0;
  logic        campaign_start = 1'b0;
  logic        campaign_busy, campaign_done, golden_fail, timeout_err;
  logic [7:0]  detected, tested;
  logic [3:0]  escape_count;
  logic [2:0]  fi_fault_type;
  logic        fi_apply_row, fi_apply_col, fi_apply_cell;
  logic [3:0]  fi_target_row, fi_target_col;
  logic [2:0]  fi_bit_sel;
  logic        fi_saf_force_value;
  logic [3:0]  fi_cf_aggr_row, fi_cf_aggr_col;
  logic        mbist_start;
  logic        mbist_done = 1'b0;
  logic        mbist_fail = 1'b0;

  fault_campaign_ctrl #(
    .ROW_ADDR_BITS(4), .COL_ADDR_BITS(4), .DATA_WIDTH(8),
    .NUM_FAULTS(8), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
    .cfg_wdata(cfg_wdata), .campaign_start(campaign_start),
    .campaign_busy(campaign_busy), .campaign_done(campaign_done),
    .golden_fail(golden_fail), .timeout_err(timeout_err),
    .detected(detected), .tested(tested), .escape_count(escape_count),
    .fi_fault_type(fi_fault_type), .fi_apply_row(fi_apply_row),
    .fi_apply_col(fi_apply_col), .fi_apply_cell(fi_apply_cell),
    .fi_target_row(fi_target_row), .fi_target_col(fi_target_col),
    .fi_bit_sel(fi_bit_sel), .fi_saf_force_value(fi_saf_force_value),
    .fi_cf_aggr_row(fi_cf_aggr_row), .fi_cf_aggr_col(fi_cf_aggr_col),
    .mbist_start(mbist_start), .mbist_done(mbist_done),
    .mbist_fail(mbist_fail)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  // MBIST model state
  logic        fail_map [8];
  int          lat = 3;
  int          cnt = -1;
  int          hang_at = 0;
  int          starts = 0;
  int          n_done = 0;
  bit          spur_en = 0;
  int          spur_cnt = 0;
  logic        prev_busy = 1'b0;
  fault_desc_t snap [16];
  int          start_cyc [16];
  int          done_cyc [16];
  int          t0;

  always @(negedge clk) begin
    fault_desc_t s;
    mbist_done = 1'b0;
    mbist_fail = 1'b0;
    if (rst) begin
      cnt = -1;
    end else begin
      if (spur_cnt > 0) begin
        spur_cnt--;
        if (spur_cnt == 0) begin
          mbist_done = 1'b1;
          mbist_fail = 1'b1;
        end
      end
      if (cnt == 0) begin
        mbist_done = 1'b1;
        mbist_fail = fail_map[int'(fi_fault_type)];
        if (n_done < 16) done_cyc[n_done] = cyc;
        n_done++;
        cnt = -1;
      end else if (cnt > 0) begin
        cnt--;
      end
      if (mbist_start === 1'b1 && starts < 16) begin
        s = '0;
        s.valid = 1'b1;
        s.fault_type = fault_e'(fi_fault_type);
        s.apply_row = fi_apply_row;
        s.apply_col = fi_apply_col;
        s.apply_cell = fi_apply_cell;
        s.target_row = fi_target_row;
        s.target_col = fi_target_col;
        s.bit_sel = fi_bit_sel;
        s.saf_force_value = fi_saf_force_value;
        s.aggr_row = fi_cf_aggr_row;
        s.aggr_col = fi_cf_aggr_col;
        snap[starts] = s;
        start_cyc[starts] = cyc;
        starts++;
        if (starts != hang_at) cnt = lat;
      end
      if (spur_en && campaign_busy && !prev_busy) begin
        spur_cnt = 1;
        spur_en = 0;
      end
    end
    prev_busy = campaign_busy;
  end

  function automatic fault_desc_t mk(
    input fault_e t, input logic ar, input logic ac, input logic acl,
    input logic [3:0] tr, input logic [3:0] tc, input logic [2:0] bs,
    input logic sf, input logic [3:0] gr, input logic [3:0] gc);
    fault_desc_t d;
    d = '{valid: 1'b1, fault_type: t, apply_row: ar, apply_col: ac,
          apply_cell: acl, target_row: tr, target_col: tc, bit_sel: bs,
          saf_force_value: sf, aggr_row: gr, aggr_col: gc};
    return d;
  endfunction

  fault_desc_t e0, e1, e2, e3, e5x, gz;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_entry(input int i, input fault_desc_t d);
    cfg_we = 1'b1;
    cfg_idx = 3'(i);
    cfg_wdata = d;
    step();
    cfg_we = 1'b0;
  endtask

  task automatic start_campaign();
    starts = 0;
    n_done = 0;
    t0 = cyc;
    campaign_start = 1'b1;
    step();
    campaign_start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (campaign_done !== 1'b1 && n < 2000) begin
      step();
      n++;
    end
    tests++;
    if (campaign_done !== 1'b1) begin
      fails++;
      $display("FAIL %s_done_timeout: campaign_done=%b want 1", name,
               campaign_done);
    end
  endtask

  task automatic test_reset();
    repeat (3) step();
    tests++;
    if ({campaign_busy, campaign_done, golden_fail, timeout_err,
         mbist_start} !== 5'b0) begin
      fails++;
      $display("FAIL reset_flags: got %b want 00000",
               {campaign_busy, campaign_done, golden_fail, timeout_err,
                mbist_start});
    end
    tests++;
    if ({detected, tested, escape_count} !== 20'h0) begin
      fails++;
      $display("FAIL reset_results: got %h want 00000",
               {detected, tested, escape_count});
    end
    tests++;
    if ({fi_fault_type, fi_apply_row, fi_apply_col, fi_apply_cell,
         fi_target_row, fi_target_col, fi_bit_sel, fi_saf_force_value,
         fi_cf_aggr_row, fi_cf_aggr_col} !== 30'h0) begin
      fails++;
      $display("FAIL reset_fi: fi_fault_type=%0d want 0", fi_fault_type);
    end
    rst = 1'b0;
    step();
    start_campaign();
    wait_done("reset_empty");
    tests++;
    if (starts !== 1 || tested !== 8'h00 || golden_fail !== 1'b0) begin
      fails++;
      $display("FAIL reset_empty_table: starts=%0d tested=%h gf=%b want 1 00 0",
               starts, tested, golden_fail);
    end
  endtask

  task automatic test_golden_fail();
    fail_map[0] = 1'b1;
    write_entry(0, e0);
    start_campaign();
    wait_done("golden_fail");
    tests++;
    if (starts !== 1) begin
      fails++;
      $display("FAIL golden_fail_starts: got %0d want 1", starts);
    end
    tests++;
    if (golden_fail !== 1'b1 || tested !== 8'h00) begin
      fails++;
      $display("FAIL golden_fail_flags: gf=%b tested=%h want 1 00",
               golden_fail, tested);
    end
    fail_map[0] = 1'b0;
  endtask

  task automatic test_full_run();
    write_entry(1, e1);
    write_entry(2, e2);
    write_entry(3, e3);
    start_campaign();
    tests++;
    if (campaign_busy !== 1'b1 || golden_fail !== 1'b0) begin
      fails++;
      $display("FAIL full_start: busy=%b gf=%b want 1 0",
               campaign_busy, golden_fail);
    end
    write_entry(5, e5x);
    wait_done("full");
    tests++;
    if (start_cyc[0] !== t0 + 3) begin
      fails++;
      $display("FAIL full_start_latency: got %0d want %0d",
               start_cyc[0] - t0, 3);
    end
    tests++;
    if (starts !== 5) begin
      fails++;
      $display("FAIL full_starts: got %0d want 5", starts);
    end
    tests++;
    if (detected !== 8'b0000_1011 || tested !== 8'b0000_1111) begin
      fails++;
      $display("FAIL full_cov: det=%b tested=%b want 00001011 00001111",
               detected, tested);
    end
    tests++;
    if (escape_count !== 4'd1) begin
      fails++;
      $display("FAIL full_escape: got %0d want 1", escape_count);
    end
    for (int k = 0; k < 5; k++) begin
      fault_desc_t want;
      case (k)
        0: want = gz;
        1: want = e0;
        2: want = e1;
        3: want = e2;
        default: want = e3;
      endcase
      tests++;
      if (snap[k] !== want) begin
        fails++;
        $display("FAIL full_fi_pass%0d: got %h want %h", k, snap[k], want);
      end
    end
    tests++;
    if (fi_fault_type !== 3'd0) begin
      fails++;
      $display("FAIL full_fi_after: got %0d want 0", fi_fault_type);
    end
  endtask

  task automatic test_restart_ignored();
    for (int k = 0; k < 8; k++) fail_map[k] = 1'b0;
    spur_en = 1;
    start_campaign();
    wait_done("restart");
    tests++;
    if (golden_fail !== 1'b0 || starts !== 5) begin
      fails++;
      $display("FAIL restart_spurious: gf=%b starts=%0d want 0 5",
               golden_fail, starts);
    end
    tests++;
    if (detected !== 8'h00 || escape_count !== 4'd4) begin
      fails++;
      $display("FAIL restart_clear: det=%h esc=%0d want 00 4",
               detected, escape_count);
    end
    tests++;
    if (tested !== 8'h0F) begin
      fails++;
      $display("FAIL busy_write_ignored: tested=%h want 0f", tested);
    end
    fail_map[1] = 1'b1;
    fail_map[2] = 1'b1;
    fail_map[4] = 1'b1;
  endtask

  task automatic test_sparse();
    for (int k = 0; k < 7; k++) write_entry(k, '0);
    write_entry(7, e1);
    lat = 10;
    start_campaign();
    wait_done("sparse");
    tests++;
    if (tested !== 8'h80 || detected !== 8'h80 || escape_count !== 4'd0) begin
      fails++;
      $display("FAIL sparse_cov: tested=%h det=%h esc=%0d want 80 80 0",
               tested, detected, escape_count);
    end
    tests++;
    if (starts !== 2 || start_cyc[1] - done_cyc[0] !== 11) begin
      fails++;
      $display("FAIL sparse_skip_time: starts=%0d gap=%0d want 2 11",
               starts, start_cyc[1] - done_cyc[0]);
    end
    tests++;
    if (snap[1] !== e1) begin
      fails++;
      $display("FAIL sparse_fi: got %h want %h", snap[1], e1);
    end
    lat = 3;
  endtask

  task automatic test_timeout();
    int n = 0;
    int t_to;
    write_entry(0, e0);
    write_entry(7, '0);
    hang_at = 2;
    start_campaign();
    while (timeout_err !== 1'b1 && n < 200) begin
      step();
      n++;
    end
    t_to = cyc;
    tests++;
    if (timeout_err !== 1'b1 || t_to - start_cyc[1] !== 17) begin
      fails++;
      $display("FAIL timeout_time: err=%b delay=%0d want 1 17",
               timeout_err, t_to - start_cyc[1]);
    end
    tests++;
    if (snap[1].fault_type !== SAF || fi_fault_type !== 3'd0) begin
      fails++;
      $display("FAIL timeout_fi: pass=%0d now=%0d want 1 0",
               snap[1].fault_type, fi_fault_type);
    end
    tests++;
    if (campaign_busy !== 1'b1 || campaign_done !== 1'b0) begin
      fails++;
      $display("FAIL timeout_in_done: busy=%b done=%b want 1 0",
               campaign_busy, campaign_done);
    end
    wait_done("timeout");
    tests++;
    if (tested !== 8'h00 || starts !== 2 || timeout_err !== 1'b1) begin
      fails++;
      $display("FAIL timeout_result: tested=%h starts=%0d err=%b want 00 2 1",
               tested, starts, timeout_err);
    end
    hang_at = 0;
  endtask

  task automatic test_mid_reset();
    int n = 0;
    write_entry(1, e1);
    lat = 4;
    start_campaign();
    while (starts < 2 && n < 200) begin
      step();
      n++;
    end
    tests++;
    if (starts !== 2) begin
      fails++;
      $display("FAIL midrst_reach_pass2: starts=%0d want 2", starts);
    end
    rst = 1'b1;
    step();
    tests++;
    if ({campaign_busy, campaign_done, golden_fail, timeout_err,
         mbist_start, fi_fault_type} !== 8'h00) begin
      fails++;
      $display("FAIL midrst_flags: got %b want 00000000",
               {campaign_busy, campaign_done, golden_fail, timeout_err,
                mbist_start, fi_fault_type});
    end
    tests++;
    if ({detected, tested, escape_count} !== 20'h0) begin
      fails++;
      $display("FAIL midrst_results: got %h want 00000",
               {detected, tested, escape_count});
    end
    rst = 1'b0;
    step();
    start_campaign();
    wait_done("midrst_empty");
    tests++;
    if (starts !== 1 || tested !== 8'h00) begin
      fails++;
      $display("FAIL midrst_valid_cleared: starts=%0d tested=%h want 1 00",
               starts, tested);
    end
    lat = 3;
  endtask

  initial begin
    for (int k = 0; k < 8; k++) fail_map[k] = 1'b0;
    fail_map[1] = 1'b1;
    fail_map[2] = 1'b1;
    fail_map[4] = 1'b1;
    e0  = mk(SAF, 0, 0, 1, 4'd3, 4'd2, 3'd0, 0, 4'd0, 4'd0);
    e1  = mk(TF,  0, 0, 1, 4'd5, 4'd6, 3'd3, 0, 4'd0, 4'd0);
    e2  = mk(AF,  1, 0, 0, 4'd1, 4'd7, 3'd0, 0, 4'd0, 4'd0);
    e3  = mk(CF,  0, 0, 1, 4'd3, 4'd4, 3'd1, 0, 4'd2, 4'd3);
    e5x = mk(TF,  0, 0, 1, 4'd9, 4'd9, 3'd7, 1, 4'd0, 4'd0);
    gz  = '0;
    gz.valid = 1'b1;
    test_reset();
    test_golden_fail();
    test_full_run();
    test_restart_ignored();
    test_sparse();
    test_timeout();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
